gnn_input_loader: RTL and testbench
===================================

# gnn_input_loader

Upstream feeder for the 4-node GNN inference top. It accepts a serial stream of 5-bit signed words over a valid/ready handshake. It assembles the 24 layer weights and the 16 node features into parallel buses, and pulses `in_ready` once per inference. It then holds all buses stable until the downstream core reports completion.

## Interface
- `DW`, 5, signed word width of weights and features.
- `N_WT`, 24, weight words per weight load.
- `N_FEAT`, 16, feature words per inference (4 nodes x 4 features).
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `s_valid`  in  1  stream word valid.
- `s_data`  in  DW  stream word, signed.
- `s_ready`  out  1  loader can accept a word; a transfer occurs when `s_valid && s_ready` at a rising edge.
- `wt_reload`  in  1  request a new weight load; honoured only in FEAT with feature count 0.
- `core_done`  in  1  downstream completion (AND of all out1_ready flags); sampled only in WAIT.
- `w_flat`  out  N_WT*DW  weights; field k at [DW*k+DW-1 : DW*k].
- `x_flat`  out  N_FEAT*DW  features; field k at [DW*k+DW-1 : DW*k].
- `in_ready`  out  1  one-cycle start pulse to the core.
- `wt_valid`  out  1  a full weight set has been loaded since reset.
- `busy`  out  1  high in FIRE and WAIT.

## Operation
- Weight order (k = 0..23):
  - k 0–3: w04, w14, w24, w34
  - k 4–7: w05..w35
  - k 8–11: w06..w36
  - k 12–15: w07..w37
  - k 16–19: w48, w58, w68, w78
  - k 20–23: w49..w79
- Feature order (k = 0..15): node n, feature i at k = 4n+i. Node0 x0..x3 first, node3 x3 last.
- One 5-bit counter `cnt` indexes the current field. Each accepted word is written verbatim into field `cnt` of the active bus. No arithmetic and no sign extension are applied.
- States:
  - LOAD_W: entered after reset. `s_ready`=1. Accepted words go to `w_flat[cnt]`. On accepting word N_WT-1: `cnt`<=0, `wt_valid`<=1, go to FEAT.
  - FEAT: `s_ready`=1. Accepted words go to `x_flat[cnt]`. On accepting word N_FEAT-1: `cnt`<=0, go to FIRE.
  - FIRE: `s_ready`=0, `in_ready`=1 for exactly this one cycle. Unconditionally go to WAIT.
  - WAIT: `s_ready`=0. When `core_done`=1, go to FEAT with `cnt`=0.
- `wt_reload` in FEAT with `cnt`==0 moves the FSM to LOAD_W. `wt_valid` stays 1.
  - If a word is accepted in the same cycle, it is written as weight 0 and `cnt`<=1.
  - `wt_reload` is ignored in FEAT with `cnt`>0 and in all other states.
- `core_done` outside WAIT is ignored. It is not latched.
- Fields not yet overwritten keep their previous value. Partial loads never clear buses.

## Timing
- Reset values (async, while `rst_n`=0):
  - state=LOAD_W, `cnt`=0
  - `w_flat`=0, `x_flat`=0
  - `in_ready`=0, `wt_valid`=0, `busy`=0
  - `s_ready`=0 while in reset; `s_ready`=1 from the first cycle after deassertion.
- All outputs are registered or decoded from the registered state only. There is no combinational path from `s_valid`, `s_data`, `core_done` or `wt_reload` to any output.
- The last feature accepted at edge E makes `in_ready` high between E and E+1. `x_flat` and `w_flat` are already final at E.
- `w_flat` and `x_flat` are stable from FIRE entry until WAIT exit.
- Minimum inference period is N_FEAT + 1 + (WAIT cycles). With `core_done` high on the first WAIT cycle, that is 18 cycles per inference.
- `s_valid` deasserting mid-load stalls `cnt`. There is no timeout.
- `rst_n` asserted in any state aborts immediately to the reset values. A partially loaded set is discarded.

## Test plan
- Reset, then stream weights 0..23 (as signed 5-bit, 0..15 and -16..-9 wrapping), then features 1..16 with `s_valid` held high.
  - Expect `wt_valid` rising after word 24.
  - Expect `in_ready` high exactly one cycle, one cycle after feature 16.
  - Expect `w_flat` field k equal to the k-th word sent, and `x_flat` field k equal to k+1.
- In WAIT, hold `s_valid`=1 with `s_data`=-16 for 10 cycles, then pulse `core_done`.
  - Expect `s_ready`=0 and buses unchanged throughout.
  - Expect `s_ready`=1 on the cycle after `core_done`.
- Second inference with features all -1 and no weight resend: `w_flat` is unchanged, `x_flat`=all 5'h1F, and one `in_ready` pulse.
- In FEAT with `cnt`=0, assert `wt_reload` together with a valid word 7.
  - Expect state LOAD_W, w04 field=7, `cnt`=1, `wt_valid` still 1.
  - Send 23 more weights and 16 features; expect exactly one `in_ready`.
- Assert `wt_reload` with `cnt`=5: ignored. `core_done` pulsed in FEAT: ignored, with no `in_ready`.
- Drop `rst_n` after 8 features.
  - Expect all outputs 0 asynchronously and `wt_valid`=0.
  - After release, expect the LOAD_W flow to restart from weight 0.

Source files
------------

// File: rtl/gnn_input_loader.sv
// Serial-to-parallel loader for the 4-node GNN core: packs 24 weights and 16 features
// from a valid/ready word stream, fires a one-cycle start pulse and holds the buses until done.
module gnn_input_loader #(
    parameter int DW     = 5,
    parameter int N_WT   = 24,
    parameter int N_FEAT = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    input  logic [DW-1:0]          s_data,
    output logic                   s_ready,
    input  logic                   wt_reload,
    input  logic                   core_done,
    output logic [N_WT*DW-1:0]     w_flat,
    output logic [N_FEAT*DW-1:0]   x_flat,
    output logic                   in_ready,
    output logic                   wt_valid,
    output logic                   busy
);

    typedef enum logic [1:0] {S_LOAD_W, S_FEAT, S_FIRE, S_WAIT} state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [4:0] r_cnt;
    logic [4:0] w_cnt_next;
    logic       r_s_ready;
    logic       r_wt_valid;
    logic       w_wt_valid_next;
    logic       w_xfer;
    logic       w_wr_w;
    logic       w_wr_x;

    assign w_xfer = s_valid && r_s_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_LOAD_W;
            r_cnt      <= '0;
            r_s_ready  <= 1'b0;
            r_wt_valid <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            // Registered so that ready stays low while reset is held.
            r_s_ready  <= (w_state_next == S_LOAD_W) || (w_state_next == S_FEAT);
            r_wt_valid <= w_wt_valid_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_wt_valid_next = r_wt_valid;
        w_wr_w          = 1'b0;
        w_wr_x          = 1'b0;
        case (r_state)
            S_LOAD_W: begin
                if (w_xfer) begin
                    w_wr_w = 1'b1;
                    if (r_cnt == 5'(N_WT - 1)) begin
                        w_cnt_next      = '0;
                        w_wt_valid_next = 1'b1;
                        w_state_next    = S_FEAT;
                    end else begin
                        w_cnt_next = r_cnt + 5'd1;
                    end
                end
            end
            S_FEAT: begin
                if (wt_reload && (r_cnt == 5'd0)) begin
                    // A word accepted alongside the reload request is weight 0.
                    w_state_next = S_LOAD_W;
                    if (w_xfer) begin
                        w_wr_w     = 1'b1;
                        w_cnt_next = 5'd1;
                    end
                end else if (w_xfer) begin
                    w_wr_x = 1'b1;
                    if (r_cnt == 5'(N_FEAT - 1)) begin
                        w_cnt_next   = '0;
                        w_state_next = S_FIRE;
                    end else begin
                        w_cnt_next = r_cnt + 5'd1;
                    end
                end
            end
            S_FIRE: w_state_next = S_WAIT;
            S_WAIT: begin
                if (core_done) begin
                    w_state_next = S_FEAT;
                    w_cnt_next   = '0;
                end
            end
            default: w_state_next = S_LOAD_W;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_WT; gi++) begin : g_wt
            logic [DW-1:0] r_field;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_field <= '0;
                else if (w_wr_w && (r_cnt == 5'(gi)))
                    r_field <= s_data;
            end
            assign w_flat[DW*gi +: DW] = r_field;
        end
        for (gi = 0; gi < N_FEAT; gi++) begin : g_ft
            logic [DW-1:0] r_field;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_field <= '0;
                else if (w_wr_x && (r_cnt == 5'(gi)))
                    r_field <= s_data;
            end
            assign x_flat[DW*gi +: DW] = r_field;
        end
    endgenerate

    assign s_ready  = r_s_ready;
    assign wt_valid = r_wt_valid;
    assign in_ready = (r_state == S_FIRE);
    assign busy     = (r_state == S_FIRE) || (r_state == S_WAIT);

endmodule

// File: tb/tb_gnn_input_loader.sv
// Directed bench for gnn_input_loader: full loads, WAIT hold, weight reload, ignored inputs, reset abort.
module tb_gnn_input_loader;

    localparam int DW = 5;
    localparam int N_WT = 24;
    localparam int N_FEAT = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 s_valid = 1'b0;
    logic [DW-1:0]        s_data = '0;
    logic                 s_ready;
    logic                 wt_reload = 1'b0;
    logic                 core_done = 1'b0;
    logic [N_WT*DW-1:0]   w_flat;
    logic [N_FEAT*DW-1:0] x_flat;
    logic                 in_ready;
    logic                 wt_valid;
    logic                 busy;

    logic [N_WT*DW-1:0]   exp_w;
    logic [N_FEAT*DW-1:0] exp_x;
    int errors = 0;
    int checks = 0;

    gnn_input_loader #(.DW(DW), .N_WT(N_WT), .N_FEAT(N_FEAT)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .wt_reload(wt_reload), .core_done(core_done), .w_flat(w_flat), .x_flat(x_flat),
        .in_ready(in_ready), .wt_valid(wt_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [DW-1:0] d);
        s_valid = 1'b1;
        s_data  = d;
        tick();
    endtask

    task automatic pulse_done();
        s_valid   = 1'b0;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
    endtask

    initial begin
        exp_w = '0;
        exp_x = '0;
        tick();
        check_eq("rst_s_ready", 128'(s_ready), 128'(0));
        check_eq("rst_busy", 128'({in_ready, wt_valid, busy}), 128'(0));
        check_eq("rst_buses", 128'({w_flat, x_flat} == '0), 128'(1));
        #2 rst_n = 1'b1;
        tick();
        check_eq("post_rst_s_ready", 128'(s_ready), 128'(1));

        // Weights 0..23 wrap into -16..-9 above 15.
        for (int k = 0; k < N_WT; k++) begin
            send_word(5'(k));
            exp_w[DW*k +: DW] = 5'(k);
            if (k == N_WT - 2) check_eq("wt_valid_early", 128'(wt_valid), 128'(0));
        end
        check_eq("wt_valid_set", 128'(wt_valid), 128'(1));
        check_eq("w_flat_load1", 128'(w_flat), 128'(exp_w));

        for (int k = 0; k < N_FEAT; k++) begin
            send_word(5'(k + 1));
            exp_x[DW*k +: DW] = 5'(k + 1);
            if (k == N_FEAT - 2) check_eq("in_ready_early", 128'(in_ready), 128'(0));
        end
        check_eq("fire_in_ready", 128'(in_ready), 128'(1));
        check_eq("fire_s_ready", 128'(s_ready), 128'(0));
        check_eq("x_flat_inf1", 128'(x_flat), 128'(exp_x));

        // WAIT: stream pressure must not leak into the buses.
        s_data = 5'h10;
        for (int c = 0; c < 10; c++) begin
            tick();
            check_eq($sformatf("wait%0d_ctl", c), 128'({s_ready, in_ready, busy}), 128'(3'b001));
        end
        check_eq("wait_buses", 128'({w_flat, x_flat}), 128'({exp_w, exp_x}));
        pulse_done();
        check_eq("done_s_ready", 128'(s_ready), 128'(1));
        check_eq("done_busy", 128'(busy), 128'(0));

        for (int k = 0; k < N_FEAT; k++) send_word(5'h1F);
        exp_x = '1;
        check_eq("inf2_in_ready", 128'(in_ready), 128'(1));
        check_eq("inf2_x", 128'(x_flat), 128'(exp_x));
        check_eq("inf2_w", 128'(w_flat), 128'(exp_w));
        s_valid = 1'b0;
        tick();
        check_eq("inf2_pulse_end", 128'(in_ready), 128'(0));
        pulse_done();

        // Reload at cnt 0 with a word in the same cycle.
        wt_reload = 1'b1;
        send_word(5'd7);
        wt_reload = 1'b0;
        exp_w[DW*0 +: DW] = 5'd7;
        check_eq("reload_w0", 128'(w_flat), 128'(exp_w));
        check_eq("reload_ctl", 128'({wt_valid, s_ready, busy}), 128'(3'b110));
        for (int k = 1; k < N_WT; k++) begin
            send_word(5'(k + 20));
            exp_w[DW*k +: DW] = 5'(k + 20);
        end
        check_eq("reload_w_all", 128'(w_flat), 128'(exp_w));
        check_eq("reload_x_kept", 128'(x_flat), 128'(exp_x));

        for (int k = 0; k < N_FEAT; k++) begin
            if (k == 5) begin
                wt_reload = 1'b1;
                core_done = 1'b1;
            end
            send_word(5'(k - 8));
            wt_reload = 1'b0;
            core_done = 1'b0;
            exp_x[DW*k +: DW] = 5'(k - 8);
            if (k == 5) begin
                check_eq("ignored_ctl", 128'({in_ready, busy, s_ready}), 128'(3'b001));
                check_eq("ignored_w", 128'(w_flat), 128'(exp_w));
            end
            check_eq($sformatf("inf3_in_ready%0d", k), 128'(in_ready), 128'(k == N_FEAT - 1));
        end
        check_eq("inf3_x", 128'(x_flat), 128'(exp_x));
        s_valid = 1'b0;
        tick();
        check_eq("inf3_pulse_end", 128'(in_ready), 128'(0));
        pulse_done();

        // Partial feature load, then reset abort.
        for (int k = 0; k < 8; k++) begin
            send_word(5'd3);
            exp_x[DW*k +: DW] = 5'd3;
        end
        check_eq("partial_x", 128'(x_flat), 128'(exp_x));
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_ctl", 128'({s_ready, in_ready, wt_valid, busy}), 128'(0));
        check_eq("async_rst_buses", 128'({w_flat, x_flat} == '0), 128'(1));
        tick();
        rst_n = 1'b1;
        s_valid = 1'b0;
        tick();
        check_eq("rst2_ctl", 128'({s_ready, wt_valid}), 128'(2'b10));
        send_word(5'd9);
        s_valid = 1'b0;
        check_eq("rst2_w0", 128'(w_flat), 128'(5'd9));
        check_eq("rst2_x", 128'(x_flat), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
